gpio_csr_unit: RTL and testbench
================================

Name: gpio_csr_unit

Overview:
Responder side of the CSR-mapped GPIO path in the RV32I core. The decoder issues `csrrw` to 0xf02 (display write) and 0xf00 (switch read). This block holds the display register and drives eight active-low seven-segment digits from it. It also synchronizes and debounces the board switches, and presents them as a 32-bit read value for the 0xf00 writeback path.

Parameters:
- NUM_SW, 18, number of physical switches; must be 1..32.
- DEBOUNCE_CYCLES, 50000, clock cycles between debounce samples; must be ≥1.
- BLANK_LZ, 1, 1 = blank leading-zero digits; digit 0 is never blanked.

Ports:
- clk_i  in  1  core clock.
- rst_n_i  in  1  asynchronous reset, active low.
- gpio_writeenable_i  in  1  display-write strobe from control unit (csrrw 0xf02).
- gpio_wdata_i  in  32  rs1 value to latch into the display register.
- switches_i  in  NUM_SW  raw asynchronous board switches.
- switches_o  out  32  debounced switches, zero-extended (csrrw 0xf00 read data).
- display_q_o  out  32  current display register (old CSR value for 0xf02 rd writeback).
- hex_o  out  56  8 digits × 7 segments; hex_o[7k+6:7k] = digit k, bit order gfedcba; a segment is lit when its bit is 0.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n_i).
  - While rst_n_i is low, all flops clear.
  - display_q_o = 0 and switches_o = 0.
  - hex_o: digit 0 = 7'h40 ("0"); digits 1–7 = 7'h7F (blank) if BLANK_LZ=1, else 7'h40.
- Reset deasserted mid-operation: sync, debounce and tick state restart from zero. The first valid switches_o update takes no fewer than 2 ticks.
- Display write:
  - gpio_writeenable_i high at rising edge N: display_q_o = gpio_wdata_i after edge N.
  - hex_o reflects the new value after edge N+1 (registered decode, 1-cycle latency).
  - With enable low, the register holds.
  - Back-to-back writes on consecutive cycles: each is latched; hex_o trails by one cycle.
- Segment decode (nibble → gfedcba):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k (k≥1) outputs 7'h7F iff nibbles k..7 are all zero.
  - Zero nibbles below a nonzero nibble display "0".
  - Value 0 shows a single "0".
- Switch synchronizer: two flops, switches_i → s1 → s2.
- Tick counter:
  - Counts 0..DEBOUNCE_CYCLES-1 and wraps to 0.
  - tick is asserted when count == DEBOUNCE_CYCLES-1.
  - DEBOUNCE_CYCLES=1 gives tick every cycle.
- Debounce, on each tick:
  - sample_q <= s2.
  - If s2 == sample_q (agreement with the previous tick), stable_q <= s2; otherwise stable_q holds.
  - switches_o = {zeros, stable_q}, registered.
  - Any pulse shorter than DEBOUNCE_CYCLES never reaches switches_o.
  - A clean change is visible within 2 + 2·DEBOUNCE_CYCLES + 1 cycles.
- Simultaneous events:
  - A display write and a switch tick in the same cycle are independent; both take effect.
  - Reset overrides everything.
- No X may propagate to outputs after reset: gpio_wdata_i is only sampled under enable.

Test Plan:
- Reset: hold rst_n_i low 3 cycles, release → display_q_o = 0; hex_o[6:0] = 7'h40; hex_o[55:7] all 7'h7F; switches_o = 0.
- Write 0x0000_00A5 at edge N:
  - display_q_o = 0x0000_00A5 after N.
  - After N+1: digit0 = 7'h12, digit1 = 7'h08, digits 2–7 = 7'h7F.
  - BLANK_LZ=0 build: digits 2–7 = 7'h40.
- Write 0x1000_0000 then 0xDEAD_BEEF on consecutive cycles:
  - First hex_o: digit7 = 7'h79, digits 0–6 = 7'h40.
  - Next cycle: digits 7..0 = 21,06,08,21,03,06,06,0E.
- DEBOUNCE_CYCLES=4: switches_i 0 → 18'h2_0001 held → switches_o = 0x0002_0001 within 11 cycles, and not before 2 ticks have elapsed.
- DEBOUNCE_CYCLES=4: 3-cycle pulse on switches_i[5], repeated with every phase offset relative to tick → switches_o never changes.
- Assert rst_n_i asynchronously mid-debounce (between ticks) and mid-write-latency → outputs return to reset values immediately, without waiting for a clock edge. After release, the write value is gone and a held switch needs ≥2 ticks to appear.

Source files
------------

// File: rtl/gpio_csr_unit.sv
// gpio_csr_unit: CSR-mapped GPIO responder for the RV32I core.
// Display register with 7-seg decode, debounced switch readback.
module gpio_csr_unit #(
  parameter int NUM_SW          = 18,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BLANK_LZ        = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              gpio_writeenable_i,
  input  logic [31:0]       gpio_wdata_i,
  input  logic [NUM_SW-1:0] switches_i,
  output logic [31:0]       switches_o,
  output logic [31:0]       display_q_o,
  output logic [55:0]       hex_o
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0] LZ_SEG =
    (BLANK_LZ != 0) ? 7'h7F : 7'h40;
  localparam logic [55:0] HEX_RST = {{7{LZ_SEG}}, 7'h40};

  logic [55:0]       hex_d;
  logic              hi_zero;
  logic [NUM_SW-1:0] s1_q;
  logic [NUM_SW-1:0] s2_q;
  logic [NUM_SW-1:0] sample_q;
  logic [NUM_SW-1:0] stable_q;
  logic [CW-1:0]     cnt_q;
  logic              tick;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    unique case (n)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      4'hF: seg7 = 7'h0E;
    endcase
  endfunction

  // Display register: latched only under the write strobe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      display_q_o <= '0;
    end else if (gpio_writeenable_i) begin
      display_q_o <= gpio_wdata_i;
    end
  end

  // Decode nibbles, blanking digits above the top nonzero one.
  always_comb begin
    hex_d   = '0;
    hi_zero = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      hi_zero = hi_zero && (display_q_o[4*k +: 4] == 4'h0);
      if (hi_zero && (k != 0) && (BLANK_LZ != 0))
        hex_d[7*k +: 7] = 7'h7F;
      else
        hex_d[7*k +: 7] = seg7(display_q_o[4*k +: 4]);
    end
  end

  // Registered segment outputs, one cycle behind the register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hex_o <= HEX_RST;
    end else begin
      hex_o <= hex_d;
    end
  end

  // Two-flop synchronizer for the raw switches.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= switches_i;
      s2_q <= s1_q;
    end
  end

  assign tick = (cnt_q == CMAX);

  // Free-running sample-interval counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Accept a value only when two consecutive ticks agree.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sample_q <= '0;
      stable_q <= '0;
    end else if (tick) begin
      sample_q <= s2_q;
      if (s2_q == sample_q) stable_q <= s2_q;
    end
  end

  assign switches_o = 32'(stable_q);

endmodule

// File: tb/tb_gpio_csr_unit.sv
// tb_gpio_csr_unit: vectors, directed corners and a
// randomized run against a reference model.
module tb_gpio_csr_unit;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [31:0] wd = '0;
  logic [17:0] sw = '0;
  logic [31:0] sw_o, sw0_o;
  logic [31:0] disp, disp0;
  logic [55:0] hex, hex0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  gpio_csr_unit #(
    .NUM_SW(18), .DEBOUNCE_CYCLES(D), .BLANK_LZ(1)
  ) u_dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .gpio_writeenable_i(we), .gpio_wdata_i(wd),
    .switches_i(sw), .switches_o(sw_o),
    .display_q_o(disp), .hex_o(hex)
  );

  gpio_csr_unit #(
    .NUM_SW(18), .DEBOUNCE_CYCLES(D), .BLANK_LZ(0)
  ) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .gpio_writeenable_i(we), .gpio_wdata_i(wd),
    .switches_i(sw), .switches_o(sw0_o),
    .display_q_o(disp0), .hex_o(hex0)
  );

  logic [6:0] segt [16];

  function automatic logic [55:0] hexm(
    input logic [31:0] v, input bit blz);
    int top;
    logic [55:0] r;
    top = 0;
    r = '0;
    for (int k = 0; k < 8; k++)
      if (v[4*k +: 4] != 0) top = k;
    for (int k = 0; k < 8; k++)
      r[7*k +: 7] = (blz && k > top) ? 7'h7F : segt[v[4*k +: 4]];
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    we = 1'b0;
    wd = '0;
    sw = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [31:0] v);
    @(negedge clk);
    we = 1'b1;
    wd = v;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic measure(input logic [31:0] tgt,
                         output int n, output int tk);
    n = 0;
    tk = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (cyc % D == 0) tk++;
      @(negedge clk);
      if (sw_o == tgt) break;
    end
  endtask

  typedef struct {
    logic [31:0] wd;
    logic [55:0] hx;
    logic [55:0] hx0;
  } vec_t;

  vec_t vt [5];

  logic [55:0] HR1, HR0, prev;
  int n, tk;
  bit bad;

  bit [31:0] dm;
  logic [55:0] hm, hm0;
  bit [17:0] stab, samp, s2;
  int c;
  logic [17:0] hist [$];
  logic rwe;
  logic [31:0] rwd;

  initial begin
    segt = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
             7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
             7'h46, 7'h21, 7'h06, 7'h0E};
    HR1 = {{7{7'h7F}}, 7'h40};
    HR0 = {8{7'h40}};

    vt[0] = '{32'h0000_00A5,
              {{6{7'h7F}}, 7'h08, 7'h12},
              {{6{7'h40}}, 7'h08, 7'h12}};
    vt[1] = '{32'h0000_0000, HR1, HR0};
    vt[2] = '{32'h1000_0000,
              {7'h79, {7{7'h40}}},
              {7'h79, {7{7'h40}}}};
    vt[3] = '{32'hDEAD_BEEF,
              {7'h21, 7'h06, 7'h08, 7'h21,
               7'h03, 7'h06, 7'h06, 7'h0E},
              {7'h21, 7'h06, 7'h08, 7'h21,
               7'h03, 7'h06, 7'h06, 7'h0E}};
    vt[4] = '{32'h0000_0F00,
              {{5{7'h7F}}, 7'h0E, 7'h40, 7'h40},
              {{5{7'h40}}, 7'h0E, 7'h40, 7'h40}};

    // Reset values
    do_reset();
    chk("rst_disp", 64'(disp), 64'h0);
    chk("rst_hex", 64'(hex), 64'(HR1));
    chk("rst_hex0", 64'(hex0), 64'(HR0));
    chk("rst_sw", 64'(sw_o), 64'h0);
    chk("rst_sw0", 64'(sw0_o), 64'h0);

    // Table: register after edge N, hex after N+1
    prev = HR1;
    for (int i = 0; i < 5; i++) begin
      wr(vt[i].wd);
      chk("tbl_disp", 64'(disp), 64'(vt[i].wd));
      chk("tbl_hex_lat", 64'(hex), 64'(prev));
      @(negedge clk);
      chk("tbl_hex", 64'(hex), 64'(vt[i].hx));
      chk("tbl_hex0", 64'(hex0), 64'(vt[i].hx0));
      prev = vt[i].hx;
    end

    // Back-to-back writes
    @(negedge clk);
    we = 1'b1;
    wd = 32'h1000_0000;
    @(negedge clk);
    chk("b2b_disp1", 64'(disp), 64'h1000_0000);
    wd = 32'hDEAD_BEEF;
    @(negedge clk);
    we = 1'b0;
    chk("b2b_disp2", 64'(disp), 64'hDEAD_BEEF);
    chk("b2b_hex1", 64'(hex), 64'(vt[2].hx));
    @(negedge clk);
    chk("b2b_hex2", 64'(hex), 64'(vt[3].hx));
    chk("b2b_hold", 64'(disp), 64'hDEAD_BEEF);

    // Clean switch change at every tick phase
    for (int off = 0; off < D; off++) begin
      do_reset();
      repeat (off) @(negedge clk);
      sw = 18'h2_0001;
      measure(32'h0002_0001, n, tk);
      chk("sw_lat", 64'(n <= 2 + 2 * D + 1), 64'h1);
      chk("sw_ticks", 64'(tk >= 2), 64'h1);
      chk("sw_val", 64'(sw_o), 64'h0002_0001);
    end

    // Short pulse at every tick phase is filtered
    for (int off = 0; off < D; off++) begin
      do_reset();
      bad = 1'b0;
      for (int t = 0; t < 30; t++) begin
        sw = (t >= 4 + off && t < 7 + off) ? 18'h20 : 18'h0;
        @(negedge clk);
        if (sw_o != 0) bad = 1'b1;
      end
      chk("pulse", 64'(bad), 64'h0);
    end

    // Async reset mid-debounce and mid-write latency
    do_reset();
    sw = 18'h2_0001;
    repeat (15) @(negedge clk);
    chk("ar_pre_sw", 64'(sw_o), 64'h0002_0001);
    @(negedge clk);
    we = 1'b1;
    wd = 32'h0000_1234;
    @(negedge clk);
    we = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_disp", 64'(disp), 64'h0);
    chk("ar_hex", 64'(hex), 64'(HR1));
    chk("ar_hex0", 64'(hex0), 64'(HR0));
    chk("ar_sw", 64'(sw_o), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    measure(32'h0002_0001, n, tk);
    chk("ar_sw_ticks", 64'(tk >= 2), 64'h1);
    chk("ar_sw_lat", 64'(n <= 2 + 2 * D + 1), 64'h1);
    chk("ar_disp_gone", 64'(disp), 64'h0);
    chk("ar_hex_gone", 64'(hex), 64'(HR1));

    // Randomized run against the reference model
    do_reset();
    dm = 0;
    hm = hexm(0, 1'b1);
    hm0 = hexm(0, 1'b0);
    stab = 0;
    samp = 0;
    c = 0;
    hist.delete();
    for (int i = 0; i < 600; i++) begin
      chk("rnd_sw", 64'(sw_o), 64'({14'b0, stab}));
      chk("rnd_disp", 64'(disp), 64'(dm));
      chk("rnd_hex", 64'(hex), 64'(hm));
      chk("rnd_hex0", 64'(hex0), 64'(hm0));
      rwe = ($urandom_range(0, 3) == 0);
      rwd = $urandom >> $urandom_range(0, 31);
      we = rwe;
      wd = rwd;
      if ($urandom_range(0, 15) == 0) sw = 18'($urandom);
      @(posedge clk);
      c++;
      hist.push_back(sw);
      if (c % D == 0) begin
        s2 = hist[c - 3];
        if (s2 == samp) stab = s2;
        samp = s2;
      end
      hm = hexm(dm, 1'b1);
      hm0 = hexm(dm, 1'b0);
      if (rwe) dm = rwd;
      @(negedge clk);
    end
    we = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
